// File: rtl/ads1115_poll_ctrl.sv
// ADS1115 single-shot conversion sequencer: drives an i2c_master command port to
// write Config, poll Config.OS with an idle gap between polls, then read Conversion.
module ads1115_poll_ctrl #(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter logic [7:0]  CFG_LSB  = 8'h83,
  parameter int unsigned POLL_GAP = 25000,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_go,
  input  logic [2:0]  i_mux,
  input  logic [2:0]  i_pga,
  output logic [15:0] o_result,
  output logic        o_valid,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy,
  output logic [6:0]  o_i2c_addr,
  output logic        o_i2c_rw,
  output logic        o_i2c_start,
  output logic [7:0]  o_i2c_wdata,
  output logic        o_i2c_wvalid,
  output logic        o_i2c_rready,
  output logic        o_i2c_stop,
  output logic        o_i2c_ack_send,
  input  logic [7:0]  i_i2c_rdata,
  input  logic        i_i2c_rvalid,
  input  logic        i_i2c_wready,
  input  logic        i_i2c_ack_recv,
  input  logic        i_i2c_done
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_PTR, S_POLL, S_CHK, S_GAP, S_CPTR, S_CRD, S_DONE, S_ESTOP, S_ERR
  } state_t;
  typedef enum logic {OP_ISSUE, OP_WAIT} op_t;
  typedef enum logic [1:0] {K_START, K_WR, K_RD, K_STOP} kind_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [2:0]         step_q, step_d;
  logic [2:0]         mux_q, mux_d, pga_q, pga_d;
  logic [7:0]         poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         msb_q, msb_d, lsb_q, lsb_d;
  logic [1:0]         code_q, code_d;
  logic [15:0]        result_q, result_d;
  logic               valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               rw_q, rw_d, start_q, start_d, wvalid_q, wvalid_d;
  logic               rready_q, rready_d, stop_q, stop_d, ack_send_q, ack_send_d;
  logic [7:0]         wdata_q, wdata_d;

  kind_t      kind;
  logic       op_rw, op_ack, op_last;
  logic [7:0] op_byte;
  state_t     next_phase;

  // Micro-op program for each bus phase, indexed by step.
  always_comb begin
    kind    = K_STOP;
    op_rw   = 1'b0;
    op_byte = 8'h00;
    op_ack  = 1'b1;
    op_last = 1'b1;
    case (state_q)
      S_CFG: begin
        op_last = (step_q == 3'd4);
        case (step_q)
          3'd0:    kind = K_START;
          3'd1:    begin kind = K_WR; op_byte = 8'h01; end
          3'd2:    begin kind = K_WR; op_byte = {1'b1, mux_q, pga_q, 1'b1}; end
          3'd3:    begin kind = K_WR; op_byte = CFG_LSB; end
          default: kind = K_STOP;
        endcase
      end
      S_PTR, S_CPTR: begin
        op_last = (step_q == 3'd2);
        case (step_q)
          3'd0:    kind = K_START;
          3'd1:    begin kind = K_WR; op_byte = (state_q == S_PTR) ? 8'h01 : 8'h00; end
          default: kind = K_STOP;
        endcase
      end
      S_POLL, S_CRD: begin
        op_last = (step_q == 3'd3);
        case (step_q)
          3'd0:    begin kind = K_START; op_rw = 1'b1; end
          3'd1:    begin kind = K_RD; op_ack = 1'b0; end
          3'd2:    begin kind = K_RD; op_ack = 1'b1; end
          default: kind = K_STOP;
        endcase
      end
      default: begin
        kind    = K_STOP;
        op_last = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (state_q)
      S_CFG:   next_phase = S_PTR;
      S_PTR:   next_phase = S_POLL;
      S_POLL:  next_phase = S_CHK;
      S_CPTR:  next_phase = S_CRD;
      S_CRD:   next_phase = S_DONE;
      default: next_phase = S_ERR;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    step_d     = step_q;
    mux_d      = mux_q;
    pga_d      = pga_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    msb_d      = msb_q;
    lsb_d      = lsb_q;
    code_d     = code_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    ack_send_d = ack_send_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    start_d    = 1'b0;
    wvalid_d   = 1'b0;
    rready_d   = 1'b0;
    stop_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_go) begin
          mux_d      = i_mux;
          pga_d      = i_pga;
          err_code_d = 2'b00;
          poll_cnt_d = 8'd0;
          busy_d     = 1'b1;
          step_d     = 3'd0;
          op_d       = OP_ISSUE;
          state_d    = S_CFG;
        end
      end

      S_CFG, S_PTR, S_POLL, S_CPTR, S_CRD, S_ESTOP: begin
        if (op_q == OP_ISSUE) begin
          case (kind)
            K_START: begin
              start_d = 1'b1;
              rw_d    = op_rw;
              op_d    = OP_WAIT;
            end
            K_WR: begin
              if (i_i2c_wready) begin
                wdata_d  = op_byte;
                wvalid_d = 1'b1;
                op_d     = OP_WAIT;
              end
            end
            K_RD: begin
              ack_send_d = op_ack;
              rready_d   = 1'b1;
              op_d       = OP_WAIT;
            end
            default: begin
              stop_d = 1'b1;
              op_d   = OP_WAIT;
            end
          endcase
        end else begin
          // The ACKed byte is the MSB, the NACKed (final) byte is the LSB.
          if (kind == K_RD && i_i2c_rvalid) begin
            if (!op_ack) msb_d = i_i2c_rdata;
            else         lsb_d = i_i2c_rdata;
          end
          if (i_i2c_done) begin
            op_d = OP_ISSUE;
            if ((kind == K_START || kind == K_WR) && i_i2c_ack_recv) begin
              code_d  = 2'b01;
              step_d  = 3'd0;
              state_d = S_ESTOP;
            end else if (op_last) begin
              step_d  = 3'd0;
              state_d = next_phase;
            end else begin
              step_d = step_q + 3'd1;
            end
          end
        end
      end

      S_CHK: begin
        if (msb_q[7]) begin
          state_d = S_CPTR;
        end else if (poll_cnt_q == 8'(POLL_MAX - 1)) begin
          code_d  = 2'b10;
          state_d = S_ERR;
        end else begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          gap_cnt_d  = '0;
          state_d    = S_GAP;
        end
      end

      // Pointer still selects Config, so the next poll goes straight to a read.
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL;
        else                                   gap_cnt_d = gap_cnt_q + 1'b1;
      end

      S_DONE: begin
        result_d = {msb_q, lsb_q};
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end

      S_ERR: begin
        err_d      = 1'b1;
        err_code_d = code_q;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ISSUE;
      step_q     <= 3'd0;
      mux_q      <= 3'd0;
      pga_q      <= 3'd0;
      poll_cnt_q <= 8'd0;
      gap_cnt_q  <= '0;
      msb_q      <= 8'd0;
      lsb_q      <= 8'd0;
      code_q     <= 2'b00;
      result_q   <= 16'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      start_q    <= 1'b0;
      wdata_q    <= 8'd0;
      wvalid_q   <= 1'b0;
      rready_q   <= 1'b0;
      stop_q     <= 1'b0;
      ack_send_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      step_q     <= step_d;
      mux_q      <= mux_d;
      pga_q      <= pga_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      msb_q      <= msb_d;
      lsb_q      <= lsb_d;
      code_q     <= code_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      start_q    <= start_d;
      wdata_q    <= wdata_d;
      wvalid_q   <= wvalid_d;
      rready_q   <= rready_d;
      stop_q     <= stop_d;
      ack_send_q <= ack_send_d;
    end
  end

  assign o_result       = result_q;
  assign o_valid        = valid_q;
  assign o_err          = err_q;
  assign o_err_code     = err_code_q;
  assign o_busy         = busy_q;
  assign o_i2c_addr     = DEV_ADDR;
  assign o_i2c_rw       = rw_q;
  assign o_i2c_start    = start_q;
  assign o_i2c_wdata    = wdata_q;
  assign o_i2c_wvalid   = wvalid_q;
  assign o_i2c_rready   = rready_q;
  assign o_i2c_stop     = stop_q;
  assign o_i2c_ack_send = ack_send_q;

endmodule

// File: tb/tb_ads1115_poll_ctrl.sv
// Bench for ads1115_poll_ctrl: command-level i2c_master plus ADS1115 register model,
// with bus-token and result scoreboards filled when each request is driven.
module tb_ads1115_poll_ctrl;
  localparam int GAP  = 16;
  localparam int PMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        go = 1'b0;
  logic [2:0]  mux = 3'd0, pga = 3'd0;
  logic [15:0] result;
  logic        valid, err, busy;
  logic [1:0]  err_code;
  logic [6:0]  i2c_addr;
  logic        i2c_rw, i2c_start, i2c_wvalid, i2c_rready, i2c_stop, i2c_ack_send;
  logic [7:0]  i2c_wdata;
  logic [7:0]  i2c_rdata = 8'h00;
  logic        i2c_rvalid = 1'b0, i2c_wready = 1'b1, i2c_ack_recv = 1'b0, i2c_done = 1'b0;

  always #5 clk = ~clk;

  ads1115_poll_ctrl #(.DEV_ADDR(7'h48), .CFG_LSB(8'h83), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_mux(mux), .i_pga(pga),
    .o_result(result), .o_valid(valid), .o_err(err), .o_err_code(err_code), .o_busy(busy),
    .o_i2c_addr(i2c_addr), .o_i2c_rw(i2c_rw), .o_i2c_start(i2c_start), .o_i2c_wdata(i2c_wdata),
    .o_i2c_wvalid(i2c_wvalid), .o_i2c_rready(i2c_rready), .o_i2c_stop(i2c_stop),
    .o_i2c_ack_send(i2c_ack_send), .i_i2c_rdata(i2c_rdata), .i_i2c_rvalid(i2c_rvalid),
    .i_i2c_wready(i2c_wready), .i_i2c_ack_recv(i2c_ack_recv), .i_i2c_done(i2c_done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Bus tokens: {00,byte} for address/data bytes, {01,..,ack} for reads, 10'h200 for STOP.
  logic [9:0]  tok_q[$];
  // Outcomes: {is_err, err_code, result}.
  logic [18:0] out_q[$];

  // Slave/master model state.
  int          busy_cnt = 0, wr_idx = 0, rd_idx = 0, poll_num = 0, ready_at = 1;
  int          cyc = 0, last_stop_cyc = 0;
  logic        nack_addr = 1'b0, pend_nack = 1'b0, pend_rd = 1'b0;
  logic [7:0]  ptr = 8'h00, pend_rdata = 8'h00;
  logic [15:0] cfg_reg = 16'h0000, conv = 16'h0000, rd_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic see_tok(input logic [9:0] t);
    if (tok_q.size() == 0) check("tok_extra", 32'(t), 32'h3FF);
    else                   check("bus_token", 32'(t), 32'(tok_q.pop_front()));
  endtask

  always @(negedge clk) begin
    i2c_done = 1'b0; i2c_rvalid = 1'b0; i2c_ack_recv = 1'b0;
    if (!rst_n) begin
      busy_cnt = 0; i2c_wready = 1'b1;
    end else begin
      if ((i2c_start | i2c_wvalid | i2c_rready | i2c_stop) && busy_cnt != 0)
        check("cmd_overlap", 32'(busy_cnt), 0);
      if (busy_cnt != 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          i2c_done = 1'b1; i2c_ack_recv = pend_nack; i2c_rvalid = pend_rd;
          i2c_rdata = pend_rdata; i2c_wready = 1'b1;
        end
      end else if (i2c_start | i2c_wvalid | i2c_rready | i2c_stop) begin
        check("one_cmd", 32'($countones({i2c_start, i2c_wvalid, i2c_rready, i2c_stop})), 1);
        pend_nack = 1'b0; pend_rd = 1'b0; busy_cnt = 2; i2c_wready = 1'b0;
        if (i2c_start) begin
          see_tok({2'b00, i2c_addr, i2c_rw});
          pend_nack = nack_addr; wr_idx = 0; rd_idx = 0;
          if (i2c_rw && ptr == 8'h01 && poll_num > 0)
            check("poll_gap", 32'((cyc - last_stop_cyc) >= GAP), 1);
        end else if (i2c_wvalid) begin
          see_tok({2'b00, i2c_wdata});
          if (wr_idx == 0) ptr = i2c_wdata;
          else if (wr_idx == 1) cfg_reg[15:8] = i2c_wdata;
          else if (wr_idx == 2) begin cfg_reg[7:0] = i2c_wdata; poll_num = 0; end
          wr_idx++;
        end else if (i2c_rready) begin
          see_tok({2'b01, 7'b0, i2c_ack_send});
          pend_rd = 1'b1;
          if (ptr == 8'h01) begin
            if (rd_idx == 0) poll_num++;
            rd_word = {(ready_at != 0 && poll_num >= ready_at), cfg_reg[14:0]};
          end else begin
            rd_word = conv;
          end
          pend_rdata = (rd_idx == 0) ? rd_word[15:8] : rd_word[7:0];
          rd_idx++;
        end else begin
          see_tok(10'h200);
          last_stop_cyc = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (valid || err)) begin
      check("valid_err_excl", 32'(valid & err), 0);
      check("busy_on_done", 32'(busy), 1);
      if (out_q.size() == 0) check("unexpected_out", 32'({valid, err}), 0);
      else begin
        logic [18:0] e;
        e = out_q.pop_front();
        check("out_kind", 32'(err), 32'(e[18]));
        if (e[18]) check("err_code", 32'(err_code), 32'(e[17:16]));
        else       check("result", 32'(result), 32'(e[15:0]));
      end
    end
  end

  task automatic push_cfg(input logic [2:0] m, input logic [2:0] p);
    tok_q.push_back(10'h090); tok_q.push_back(10'h001);
    tok_q.push_back({2'b00, 1'b1, m, p, 1'b1}); tok_q.push_back(10'h083); tok_q.push_back(10'h200);
  endtask
  task automatic push_wptr(input logic [7:0] b);
    tok_q.push_back(10'h090); tok_q.push_back({2'b00, b}); tok_q.push_back(10'h200);
  endtask
  task automatic push_read();
    tok_q.push_back(10'h091); tok_q.push_back(10'h100); tok_q.push_back(10'h101); tok_q.push_back(10'h200);
  endtask

  // Full expected bus traffic for a sequence; ready_on==0 means OS never sets.
  task automatic push_seq(input logic [2:0] m, input logic [2:0] p, input int ready_on);
    int polls;
    push_cfg(m, p); push_wptr(8'h01);
    polls = (ready_on == 0) ? PMAX : ready_on;
    for (int i = 0; i < polls; i++) push_read();
    if (ready_on != 0) begin push_wptr(8'h00); push_read(); end
  endtask

  task automatic pulse_go(input logic [2:0] m, input logic [2:0] p);
    @(negedge clk); go = 1'b1; mux = m; pga = p;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((out_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check({tag, "_timeout"}, 0, 1);
    check({tag, "_tokens_left"}, 32'(tok_q.size()), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid_err"}, 32'({valid, err}), 0);
    check({tag, "_err_code"}, 32'(err_code), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_pulses"}, 32'({i2c_start, i2c_wvalid, i2c_rready, i2c_stop, i2c_rw}), 0);
    check({tag, "_ack_send"}, 32'(i2c_ack_send), 1);
    check({tag, "_addr"}, 32'(i2c_addr), 32'h48);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    #29 rst_n = 1'b1;

    // Ready on first poll.
    ready_at = 1; conv = 16'h1234; nack_addr = 1'b0;
    push_seq(3'b100, 3'b001, 1); out_q.push_back({3'b000, 16'h1234});
    pulse_go(3'b100, 3'b001);
    check("busy_after_go", 32'(busy), 1);
    wait_idle("first_poll");

    // Ready on third poll: gap checked between polls.
    ready_at = 3; conv = 16'h7FFF;
    push_seq(3'b000, 3'b010, 3); out_q.push_back({3'b000, 16'h7FFF});
    pulse_go(3'b000, 3'b010);
    wait_idle("third_poll");

    // OS never sets: PMAX polls then timeout error.
    ready_at = 0;
    push_seq(3'b011, 3'b111, 0); out_q.push_back({3'b110, 16'h0000});
    pulse_go(3'b011, 3'b111);
    wait_idle("timeout");
    repeat (5) @(negedge clk);
    check("err_code_held", 32'(err_code), 2);

    // Address NACK: STOP then NACK error.
    nack_addr = 1'b1;
    tok_q.push_back(10'h090); tok_q.push_back(10'h200); out_q.push_back({3'b101, 16'h0000});
    pulse_go(3'b001, 3'b001);
    check("err_code_cleared", 32'(err_code), 0);
    wait_idle("nack");
    nack_addr = 1'b0;

    // Negative full scale, with go pulses during busy ignored.
    ready_at = 1; conv = 16'h8000;
    push_seq(3'b101, 3'b000, 1); out_q.push_back({3'b000, 16'h8000});
    pulse_go(3'b101, 3'b000);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      pulse_go(3'b010, 3'b110);
    end
    wait_idle("busy_go");
    repeat (40) @(negedge clk);
    check("busy_go_no_extra", 32'(tok_q.size() + out_q.size()), 0);

    // Reset during a POLL read, then a normal sequence.
    begin
      int n;
      logic found;
      ready_at = 2; conv = 16'h5555; found = 1'b0;
      push_seq(3'b000, 3'b000, 2); out_q.push_back({3'b000, 16'h5555});
      pulse_go(3'b000, 3'b000);
      n = 0;
      while (!found && n < 2000) begin
        @(negedge clk); n++;
        if (i2c_rready && ptr == 8'h01) found = 1'b1;
      end
      check("reach_poll_read", 32'(found), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midreset");
      tok_q.delete(); out_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
    end
    ready_at = 1; conv = 16'h0F0F;
    push_seq(3'b110, 3'b011, 1); out_q.push_back({3'b000, 16'h0F0F});
    pulse_go(3'b110, 3'b011);
    wait_idle("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
